sdram_requester: RTL and testbench

SDRAM_REQUESTER -- requirements
Module: sdram_requester

---
 rtl/sdram_requester.sv | 180 ++++++++++++++++++
 tb/tb_sdram_requester.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_requester.sv
// rtl/sdram_requester.sv - request FIFO and single-outstanding issue FSM in front of an SDRAM controller
module sdram_requester #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        SDRAM_CONTROLLER_CLK,
    input  logic        Reset,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [24:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        WR_DONE,
    output logic        READY_INIT,
    output logic        ERR_TIMEOUT,
    input  logic        INIT_DONE,
    input  logic        RW_ACK,
    input  logic [31:0] DATA_READ,
    output logic        RW_READ,
    output logic        RW_WRITE,
    output logic [24:0] DATA_ADDR,
    output logic [31:0] DATA_WRITE
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EW = 1 + 25 + 32;

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        IDLE      = 2'd1,
        ISSUE     = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [EW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [EW-1:0]  head;
    logic           push;
    logic           pop;
    logic           fifo_empty;

    logic [TW-1:0]  tmr_cnt;
    logic           timeout_hit;
    logic           load;
    logic           ack_take;
    logic           tmo;

    assign REQ_READY   = (count != (AW+1)'(FIFO_DEPTH));
    assign fifo_empty  = (count == '0);
    assign push        = REQ_VALID & REQ_READY;
    assign pop         = ack_take | tmo;
    assign head        = fifo_mem[rd_ptr];
    assign timeout_hit = (tmr_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Storage has no reset; occupancy and pointers alone define validity.
    always_ff @(posedge SDRAM_CONTROLLER_CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {REQ_WE, REQ_ADDR, REQ_WDATA};
        end
    end

    always_ff @(posedge SDRAM_CONTROLLER_CLK) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge SDRAM_CONTROLLER_CLK) begin
        if (Reset) begin
            state <= WAIT_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ack_take  = 1'b0;
        tmo       = 1'b0;
        case (state)
            WAIT_INIT: begin
                if (INIT_DONE) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (!fifo_empty) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // An acknowledge on the final allowed cycle still wins over the timeout.
                if (RW_ACK) begin
                    ack_take  = 1'b1;
                    state_nxt = GAP;
                end else if (timeout_hit) begin
                    tmo       = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = WAIT_INIT;
            end
        endcase
    end

    always_ff @(posedge SDRAM_CONTROLLER_CLK) begin
        if (Reset) begin
            RW_READ     <= 1'b0;
            RW_WRITE    <= 1'b0;
            DATA_ADDR   <= '0;
            DATA_WRITE  <= '0;
            RSP_VALID   <= 1'b0;
            RSP_RDATA   <= '0;
            WR_DONE     <= 1'b0;
            READY_INIT  <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
            tmr_cnt     <= '0;
        end else begin
            RSP_VALID <= 1'b0;
            WR_DONE   <= 1'b0;
            if (state == WAIT_INIT && INIT_DONE) begin
                READY_INIT <= 1'b1;
            end
            if (load) begin
                RW_WRITE   <= head[EW-1];
                RW_READ    <= ~head[EW-1];
                DATA_ADDR  <= head[56:32];
                DATA_WRITE <= head[31:0];
                tmr_cnt    <= '0;
            end
            if (state == ISSUE) begin
                tmr_cnt <= tmr_cnt + TW'(1);
            end
            if (ack_take) begin
                RW_READ  <= 1'b0;
                RW_WRITE <= 1'b0;
                if (RW_READ) begin
                    RSP_RDATA <= DATA_READ;
                    RSP_VALID <= 1'b1;
                end else begin
                    WR_DONE <= 1'b1;
                end
            end
            if (tmo) begin
                RW_READ     <= 1'b0;
                RW_WRITE    <= 1'b0;
                ERR_TIMEOUT <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_requester.sv
// tb/tb_sdram_requester.sv - directed table plus randomized queue-model checks for sdram_requester
module tb_sdram_requester;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic        clk;
    logic        Reset;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [24:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        WR_DONE;
    logic        READY_INIT;
    logic        ERR_TIMEOUT;
    logic        INIT_DONE;
    logic        RW_ACK;
    logic [31:0] DATA_READ;
    logic        RW_READ;
    logic        RW_WRITE;
    logic [24:0] DATA_ADDR;
    logic [31:0] DATA_WRITE;

    sdram_requester #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .SDRAM_CONTROLLER_CLK(clk),
        .Reset(Reset),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID),
        .RSP_RDATA(RSP_RDATA),
        .WR_DONE(WR_DONE),
        .READY_INIT(READY_INIT),
        .ERR_TIMEOUT(ERR_TIMEOUT),
        .INIT_DONE(INIT_DONE),
        .RW_ACK(RW_ACK),
        .DATA_READ(DATA_READ),
        .RW_READ(RW_READ),
        .RW_WRITE(RW_WRITE),
        .DATA_ADDR(DATA_ADDR),
        .DATA_WRITE(DATA_WRITE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [24:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic        exp_tmo;
    } txn_t;

    typedef struct {
        logic        we;
        logic [24:0] addr;
        logic [31:0] wdata;
    } req_t;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic        err_model = 1'b0;
    logic [31:0] last_rdata = '0;
    txn_t        tbl [8];
    req_t        q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_req(input logic we, input logic [24:0] addr, input logic [31:0] wdata);
        REQ_VALID = 1'b1;
        REQ_WE    = we;
        REQ_ADDR  = addr;
        REQ_WDATA = wdata;
        check("push_ready", {31'd0, REQ_READY}, 32'd1);
        tick();
        REQ_VALID = 1'b0;
    endtask

    // Wait for the head request to issue, hold it for 'delay' cycles, then acknowledge.
    task automatic serve(input logic we, input logic [24:0] addr, input logic [31:0] wdata,
                         input int delay, input logic [31:0] rdata, input logic exp_tmo);
        int  w;
        int  k;
        bit  done;
        w = 0;
        while (!(RW_READ | RW_WRITE) && w < 20) begin
            tick();
            w++;
        end
        check("issue_seen", {31'd0, RW_READ | RW_WRITE}, 32'd1);
        k = 0;
        done = 1'b0;
        while (!done) begin
            check("strobe_wr", {31'd0, RW_WRITE}, {31'd0, we});
            check("strobe_rd", {31'd0, RW_READ}, {31'd0, ~we});
            check("addr", {7'd0, DATA_ADDR}, {7'd0, addr});
            if (we) check("wdata", DATA_WRITE, wdata);
            if (k == delay) begin
                RW_ACK    = 1'b1;
                DATA_READ = rdata;
            end
            tick();
            RW_ACK    = 1'b0;
            DATA_READ = $urandom;
            if (k == delay || k == TMO - 1) done = 1'b1;
            k++;
        end
        check("strobes_off", {30'd0, RW_READ, RW_WRITE}, 32'd0);
        if (exp_tmo) begin
            err_model = 1'b1;
            check("tmo_no_rsp", {30'd0, RSP_VALID, WR_DONE}, 32'd0);
        end else if (we) begin
            check("wr_done", {30'd0, RSP_VALID, WR_DONE}, 32'd1);
        end else begin
            last_rdata = rdata;
            check("rsp_valid", {30'd0, RSP_VALID, WR_DONE}, 32'd2);
        end
        check("rsp_rdata", RSP_RDATA, last_rdata);
        check("err_timeout", {31'd0, ERR_TIMEOUT}, {31'd0, err_model});
        tick();
        check("pulse_end", {30'd0, RSP_VALID, WR_DONE}, 32'd0);
        check("gap_low", {30'd0, RW_READ, RW_WRITE}, 32'd0);
        check("rdata_hold", RSP_RDATA, last_rdata);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        err_model  = 1'b0;
        last_rdata = '0;
    endtask

    task automatic do_init();
        INIT_DONE = 1'b1;
        tick();
        INIT_DONE = 1'b0;
        check("ready_init", {31'd0, READY_INIT}, 32'd1);
    endtask

    initial begin
        int          w;
        int          cyc;
        int          k;
        int          dly;
        int          since_ack;
        int          rsp_pend;
        logic [31:0] rsp_data;
        bit          in_issue;
        bit          ack;

        Reset = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
        INIT_DONE = 1'b0; RW_ACK = 1'b0; DATA_READ = '0;

        tbl[0] = '{1'b0, 25'h0000010, 32'h0,        6,  32'hDEADBEEF, 1'b0};
        tbl[1] = '{1'b1, 25'h1FFFFFF, 32'h12345678, 3,  32'h0,        1'b0};
        tbl[2] = '{1'b0, 25'h1FFFFFF, 32'h0,        3,  32'hCAFEF00D, 1'b0};
        tbl[3] = '{1'b1, 25'h0AAAAAA, 32'hA5A5A5A5, 0,  32'h0,        1'b0};
        tbl[4] = '{1'b0, 25'h1555555, 32'h0,        0,  32'h00000001, 1'b0};
        tbl[5] = '{1'b1, 25'h0800400, 32'hFFFFFFFF, 9,  32'h0,        1'b1};
        tbl[6] = '{1'b0, 25'h0000001, 32'h0,        20, 32'h77777777, 1'b1};
        tbl[7] = '{1'b0, 25'h0000002, 32'h0,        7,  32'h13572468, 1'b0};

        tick();
        tick();
        check("rst_strobes", {30'd0, RW_READ, RW_WRITE}, 32'd0);
        check("rst_pulses", {30'd0, RSP_VALID, WR_DONE}, 32'd0);
        check("rst_sticky", {30'd0, READY_INIT, ERR_TIMEOUT}, 32'd0);
        check("rst_ready", {31'd0, REQ_READY}, 32'd1);
        check("rst_rdata", RSP_RDATA, 32'd0);
        check("rst_addr", {7'd0, DATA_ADDR}, 32'd0);
        Reset = 1'b0;

        // Request accepted before init is held back until INIT_DONE.
        push_req(1'b0, 25'h0000010, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("pre_init_rd", {31'd0, RW_READ}, 32'd0);
            tick();
        end
        do_init();
        check("init_no_strobe", {31'd0, RW_READ}, 32'd0);
        tick();
        check("init_rd", {31'd0, RW_READ}, 32'd1);
        check("init_addr", {7'd0, DATA_ADDR}, 32'h0000010);
        serve(1'b0, 25'h0000010, 32'h0, 6, 32'hDEADBEEF, 1'b0);

        for (int i = 0; i < 8; i++) begin
            push_req(tbl[i].we, tbl[i].addr, tbl[i].wdata);
            serve(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].delay, tbl[i].rdata, tbl[i].exp_tmo);
        end

        // Fill the FIFO: fifth write stalls until the first acknowledge frees a slot.
        do_reset();
        do_init();
        for (int i = 0; i < 4; i++) begin
            push_req(1'b1, 25'(32'h100 + i), 32'hA0 + i);
        end
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 25'h104; REQ_WDATA = 32'hA4;
        check("full_ready", {31'd0, REQ_READY}, 32'd0);
        check("full_w0", {31'd0, RW_WRITE}, 32'd1);
        check("full_w0_addr", {7'd0, DATA_ADDR}, 32'h100);
        RW_ACK = 1'b1;
        tick();
        RW_ACK = 1'b0;
        check("pop_ready", {31'd0, REQ_READY}, 32'd1);
        check("pop_wr_done", {31'd0, WR_DONE}, 32'd1);
        tick();
        REQ_VALID = 1'b0;
        for (int i = 1; i < 5; i++) begin
            serve(1'b1, 25'(32'h100 + i), 32'hA0 + i, 1, 32'h0, 1'b0);
        end

        // Back-to-back spacing: strobe returns on the third cycle after the ACK cycle.
        push_req(1'b1, 25'h1FFFFFF, 32'h55);
        push_req(1'b0, 25'h1FFFFFF, 32'h0);
        w = 0;
        while (!(RW_READ | RW_WRITE) && w < 10) begin tick(); w++; end
        RW_ACK = 1'b1;
        tick();
        RW_ACK = 1'b0;
        check("spc_ack", {30'd0, RW_READ, RW_WRITE}, 32'd0);
        tick();
        check("spc_idle", {30'd0, RW_READ, RW_WRITE}, 32'd0);
        tick();
        check("spc_reissue", {30'd0, RW_READ, RW_WRITE}, 32'd2);
        serve(1'b0, 25'h1FFFFFF, 32'h0, 3, 32'h2468ACE0, 1'b0);

        // Reset coincident with ACK while other entries wait in the FIFO.
        push_req(1'b0, 25'h0000123, 32'h0);
        push_req(1'b1, 25'h0000124, 32'h9);
        push_req(1'b1, 25'h0000125, 32'hA);
        check("rst_in_issue", {31'd0, RW_READ}, 32'd1);
        Reset = 1'b1; RW_ACK = 1'b1; DATA_READ = 32'hBAD0BAD0;
        tick();
        Reset = 1'b0; RW_ACK = 1'b0;
        last_rdata = '0;
        err_model  = 1'b0;
        check("rst_ack_rsp", {30'd0, RSP_VALID, WR_DONE}, 32'd0);
        check("rst_ack_rdata", RSP_RDATA, 32'd0);
        check("rst_ack_ready", {31'd0, REQ_READY}, 32'd1);
        check("rst_ack_init", {31'd0, READY_INIT}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_wait_init", {30'd0, RW_READ, RW_WRITE}, 32'd0);
        end
        do_init();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_fifo_empty", {30'd0, RW_READ, RW_WRITE}, 32'd0);
        end

        // Randomized traffic against a queue model of the request stream.
        in_issue = 1'b0; k = 0; dly = 0; since_ack = 99; rsp_pend = 0; rsp_data = '0;
        cyc = 0;
        while ((cyc < 600 || q.size() != 0 || in_issue) && cyc < 3000) begin
            check("r_ready", {31'd0, REQ_READY}, {31'd0, q.size() < DEPTH});
            check("r_excl", {31'd0, RW_READ & RW_WRITE}, 32'd0);
            if (since_ack < 2) check("r_gap", {30'd0, RW_READ, RW_WRITE}, 32'd0);
            check("r_rsp", {30'd0, RSP_VALID, WR_DONE}, rsp_pend);
            check("r_rdata", RSP_RDATA, last_rdata);
            check("r_sticky", {30'd0, READY_INIT, ERR_TIMEOUT}, 32'd2);
            rsp_pend = 0;
            since_ack++;
            ack = 1'b0;
            DATA_READ = $urandom;
            INIT_DONE = ($urandom_range(0, 15) == 0);
            if (RW_READ | RW_WRITE) begin
                if (q.size() == 0) begin
                    check("r_spurious_issue", {31'd0, RW_READ | RW_WRITE}, 32'd0);
                end else begin
                    check("r_we", {30'd0, RW_READ, RW_WRITE}, q[0].we ? 32'd1 : 32'd2);
                    check("r_addr", {7'd0, DATA_ADDR}, {7'd0, q[0].addr});
                    if (q[0].we) check("r_wdata", DATA_WRITE, q[0].wdata);
                    if (!in_issue) begin
                        in_issue = 1'b1;
                        k = 0;
                        dly = $urandom_range(0, TMO - 2);
                    end
                    if (k == dly) begin
                        ack = 1'b1;
                        rsp_pend = q[0].we ? 1 : 2;
                        if (!q[0].we) last_rdata = DATA_READ;
                        void'(q.pop_front());
                        in_issue = 1'b0;
                        since_ack = 0;
                    end else begin
                        k++;
                    end
                end
                RW_ACK = ack;
            end else begin
                RW_ACK = ($urandom_range(0, 7) == 0);
            end
            REQ_VALID = (cyc < 600) && ($urandom_range(0, 1) == 1);
            REQ_WE    = $urandom_range(0, 1) == 1;
            REQ_ADDR  = 25'($urandom);
            REQ_WDATA = $urandom;
            if (REQ_VALID && REQ_READY) begin
                q.push_back('{REQ_WE, REQ_ADDR, REQ_WDATA});
            end
            tick();
            RW_ACK = 1'b0;
            REQ_VALID = 1'b0;
            INIT_DONE = 1'b0;
            cyc++;
        end
        check("r_drained", {31'd0, q.size() == 0 && !in_issue}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
